// File: rtl/i2c_arbiter_pkg.sv
// Shared types for the I2C requester arbiter: FSM states, latched command
// layout and read/write encoding.
package i2c_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    RUN    = 3'd2,
    FINISH = 3'd3,
    ABORT  = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] addr_h;
    logic [7:0] addr_l;
    logic       addr16;
    logic [7:0] len;
    logic       rw;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Command/status bundle between the arbiter (master) and the shared I2C
// controller (slave).
interface i2c_arbiter_if;

  logic [7:0] i2c_device_addr;
  logic [7:0] i2c_word_addr_h;
  logic [7:0] i2c_word_addr_l;
  logic       i2c_num_word_addr;
  logic [7:0] i2c_num_data_w;
  logic [7:0] i2c_num_data_r;
  logic       i2c_wen;
  logic       i2c_ren;
  logic [7:0] i2c_wdata;
  logic       i2c_wvalid;
  logic       i2c_rvalid;
  logic       i2c_done;
  logic       i2c_error;
  logic [7:0] i2c_rdata;

  modport master (
    output i2c_device_addr, i2c_word_addr_h, i2c_word_addr_l, i2c_num_word_addr,
           i2c_num_data_w, i2c_num_data_r, i2c_wen, i2c_ren, i2c_wdata,
    input  i2c_wvalid, i2c_rvalid, i2c_done, i2c_error, i2c_rdata
  );

  modport slave (
    input  i2c_device_addr, i2c_word_addr_h, i2c_word_addr_l, i2c_num_word_addr,
           i2c_num_data_w, i2c_num_data_r, i2c_wen, i2c_ren, i2c_wdata,
    output i2c_wvalid, i2c_rvalid, i2c_done, i2c_error, i2c_rdata
  );

endinterface

// File: rtl/i2c_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, as one-hot grant plus index.
module rr_select #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin sequencer sharing one I2C controller among NUM_REQ requesters,
// with a per-transaction watchdog.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_rw,
  input  logic [NUM_REQ-1:0][7:0]  req_dev,
  input  logic [NUM_REQ-1:0][15:0] req_addr,
  input  logic [NUM_REQ-1:0]       req_addr16,
  input  logic [NUM_REQ-1:0][7:0]  req_len,
  input  logic [NUM_REQ-1:0][7:0]  req_wdata,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic [NUM_REQ-1:0]       req_wack,
  output logic [7:0]               req_rdata,
  output logic [NUM_REQ-1:0]       req_rvalid,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_error,
  i2c_arbiter_if.master            i2c
);

  localparam int unsigned IW   = $clog2(NUM_REQ);
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  i2c_cmd_t           cmd_q, cmd_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] wack_q, wack_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [7:0]         rdata_q, rdata_d;

  logic [NUM_REQ-1:0] sel_gnt;
  logic [IW-1:0]      sel_idx;
  logic               sel_any;
  logic [WD_W:0]      wd_inc;
  logic               wd_expire;
  logic               run;

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign run = (state_q == RUN);

  // Expiry looks one count ahead so the enables are high for exactly
  // TIMEOUT_CYCLES cycles before ABORT.
  always_comb begin
    wd_inc    = {1'b0, wd_q} + 1'b1;
    wd_expire = (TIMEOUT_CYCLES != 0) && (wd_inc >= (WD_W + 1)'(TIMEOUT_CYCLES));
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cmd_d    = cmd_q;
    wd_d     = wd_q;
    err_d    = err_q;
    wack_d   = (run && i2c.i2c_wvalid) ? grant_q : '0;
    rvalid_d = (run && i2c.i2c_rvalid) ? grant_q : '0;
    rdata_d  = (run && i2c.i2c_rvalid) ? i2c.i2c_rdata : rdata_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          grant_d = sel_gnt;
          owner_d = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        cmd_d.dev    = req_dev[owner_q];
        cmd_d.addr_h = req_addr[owner_q][15:8];
        cmd_d.addr_l = req_addr[owner_q][7:0];
        cmd_d.addr16 = req_addr16[owner_q];
        cmd_d.len    = req_len[owner_q];
        cmd_d.rw     = req_rw[owner_q];
        wd_d         = '0;
        state_d      = RUN;
      end
      RUN: begin
        wd_d = wd_inc[WD_W] ? wd_q : wd_inc[WD_W-1:0];
        if (i2c.i2c_done || i2c.i2c_error) begin
          err_d   = i2c.i2c_error;
          state_d = FINISH;
        end else if (wd_expire) begin
          state_d = ABORT;
        end
      end
      FINISH, ABORT: begin
        ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      cmd_q    <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      wack_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cmd_q    <= cmd_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      wack_q   <= wack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    req_done  = '0;
    req_error = '0;
    if (state_q == FINISH) begin
      req_done  = grant_q;
      req_error = err_q ? grant_q : '0;
    end else if (state_q == ABORT) begin
      req_done  = grant_q;
      req_error = grant_q;
    end
  end

  assign req_grant  = grant_q;
  assign req_wack   = wack_q;
  assign req_rvalid = rvalid_q;
  assign req_rdata  = rdata_q;

  assign i2c.i2c_device_addr   = cmd_q.dev;
  assign i2c.i2c_word_addr_h   = cmd_q.addr_h;
  assign i2c.i2c_word_addr_l   = cmd_q.addr_l;
  assign i2c.i2c_num_word_addr = cmd_q.addr16;
  assign i2c.i2c_num_data_w    = (cmd_q.rw == RW_WRITE) ? cmd_q.len : '0;
  assign i2c.i2c_num_data_r    = (cmd_q.rw == RW_READ) ? cmd_q.len : '0;
  assign i2c.i2c_wen           = run && (cmd_q.rw == RW_WRITE);
  assign i2c.i2c_ren           = run && (cmd_q.rw == RW_READ);
  assign i2c.i2c_wdata         = run ? req_wdata[owner_q] : '0;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scenario bench for i2c_arbiter: the bench plays the I2C controller and the
// requesters, queueing expected per-byte results as it drives them.
module tb_i2c_arbiter;
  import i2c_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 100;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid, req_rw, req_addr16;
  logic [N-1:0][7:0]   req_dev, req_len, req_wdata;
  logic [N-1:0][15:0]  req_addr;
  logic [N-1:0]        req_grant, req_wack, req_rvalid, req_done, req_error;
  logic [7:0]          req_rdata;

  i2c_arbiter_if bus();

  i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_dev    (req_dev),
    .req_addr   (req_addr),
    .req_addr16 (req_addr16),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .req_grant  (req_grant),
    .req_wack   (req_wack),
    .req_rdata  (req_rdata),
    .req_rvalid (req_rvalid),
    .req_done   (req_done),
    .req_error  (req_error),
    .i2c        (bus)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [7:0]   rd_q[$];
  logic [N-1:0] wack_q[$];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_all;
    req_valid = '0; req_rw = '0; req_addr16 = '0;
    req_dev = '0; req_len = '0; req_wdata = '0; req_addr = '0;
    bus.i2c_wvalid = 1'b0; bus.i2c_rvalid = 1'b0;
    bus.i2c_done = 1'b0; bus.i2c_error = 1'b0; bus.i2c_rdata = '0;
  endtask

  task automatic wait_grant;
    for (int c = 0; c < 10 && req_grant == '0; c++) tick();
  endtask

  task automatic wait_enable;
    for (int c = 0; c < 10 && !(bus.i2c_wen || bus.i2c_ren); c++) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_all();
    tick(); tick();
    total++; if (req_grant !== '0) $display("FAIL reset_grant got=%b exp=0", req_grant); else passed++;
    total++; if ({req_done, req_error, req_wack, req_rvalid} !== '0)
      $display("FAIL reset_pulses got=%h exp=0", {req_done, req_error, req_wack, req_rvalid}); else passed++;
    total++; if (req_rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", req_rdata); else passed++;
    total++; if ({bus.i2c_wen, bus.i2c_ren} !== 2'b00) $display("FAIL reset_enables got=%b exp=00", {bus.i2c_wen, bus.i2c_ren}); else passed++;
    total++; if ({bus.i2c_device_addr, bus.i2c_num_data_w, bus.i2c_num_data_r, bus.i2c_wdata} !== '0)
      $display("FAIL reset_cmd got=%h exp=0", {bus.i2c_device_addr, bus.i2c_num_data_w, bus.i2c_num_data_r, bus.i2c_wdata}); else passed++;
    rst = 1'b0;
    tick(); tick();
    total++; if (req_grant !== '0) $display("FAIL idle_no_grant got=%b exp=0", req_grant); else passed++;
  endtask

  task automatic test_single_write;
    logic [7:0]   b;
    logic [N-1:0] e;
    int unsigned  wacks;
    wacks = 0;
    req_valid[0] = 1'b1; req_rw[0] = RW_WRITE; req_dev[0] = 8'hA0;
    req_addr[0] = 16'h0010; req_addr16[0] = 1'b0; req_len[0] = 8'd2;
    tick();
    total++; if (req_grant !== 4'b0001) $display("FAIL wr_grant_n1 got=%b exp=0001", req_grant); else passed++;
    total++; if (bus.i2c_wen !== 1'b0) $display("FAIL wr_wen_n1 got=%b exp=0", bus.i2c_wen); else passed++;
    tick();
    total++; if ({bus.i2c_wen, bus.i2c_ren} !== 2'b10) $display("FAIL wr_enables_n2 got=%b exp=10", {bus.i2c_wen, bus.i2c_ren}); else passed++;
    total++; if (bus.i2c_device_addr !== 8'hA0 || bus.i2c_word_addr_l !== 8'h10 || bus.i2c_num_word_addr !== 1'b0)
      $display("FAIL wr_cmd_addr got=%h/%h/%b exp=a0/10/0", bus.i2c_device_addr, bus.i2c_word_addr_l, bus.i2c_num_word_addr); else passed++;
    total++; if (bus.i2c_num_data_w !== 8'd2 || bus.i2c_num_data_r !== 8'd0)
      $display("FAIL wr_num_data got=w%0d r%0d exp=w2 r0", bus.i2c_num_data_w, bus.i2c_num_data_r); else passed++;
    for (int k = 0; k < 3; k++) begin
      b = 8'h5A + 8'(k);
      req_wdata[0] = b;
      #1;
      total++; if (bus.i2c_wdata !== b) $display("FAIL wr_wdata_mux[%0d] got=%h exp=%h", k, bus.i2c_wdata, b); else passed++;
      bus.i2c_wvalid = 1'b1;
      wack_q.push_back(4'b0001);
      tick();
      bus.i2c_wvalid = 1'b0;
      if (req_wack[0]) wacks++;
      e = wack_q.pop_front();
      total++; if (req_wack !== e) $display("FAIL wr_wack[%0d] got=%b exp=%b", k, req_wack, e); else passed++;
      tick();
      if (req_wack[0]) wacks++;
    end
    total++; if (wacks != 3) $display("FAIL wr_wack_count got=%0d exp=3", wacks); else passed++;
    bus.i2c_done = 1'b1;
    tick();
    bus.i2c_done = 1'b0;
    total++; if (req_done !== 4'b0001 || req_error !== 4'b0000)
      $display("FAIL wr_done got=%b/%b exp=0001/0000", req_done, req_error); else passed++;
    total++; if ({bus.i2c_wen, bus.i2c_ren} !== 2'b00 || req_grant !== 4'b0001)
      $display("FAIL wr_finish got=en%b grant%b exp=en00 grant0001", {bus.i2c_wen, bus.i2c_ren}, req_grant); else passed++;
    req_valid[0] = 1'b0;
    tick();
    total++; if (req_grant !== '0 || req_done !== '0) $display("FAIL wr_release got=%b/%b exp=0/0", req_grant, req_done); else passed++;
  endtask

  task automatic test_read16;
    logic [7:0]  b, e;
    int unsigned rv;
    rv = 0;
    req_valid[2] = 1'b1; req_rw[2] = RW_READ; req_dev[2] = 8'hA1;
    req_addr[2] = 16'h1234; req_addr16[2] = 1'b1; req_len[2] = 8'd3;
    tick();
    total++; if (req_grant !== 4'b0100) $display("FAIL rd_grant got=%b exp=0100", req_grant); else passed++;
    tick();
    total++; if ({bus.i2c_wen, bus.i2c_ren} !== 2'b01) $display("FAIL rd_enables got=%b exp=01", {bus.i2c_wen, bus.i2c_ren}); else passed++;
    total++; if (bus.i2c_word_addr_h !== 8'h12 || bus.i2c_word_addr_l !== 8'h34 || bus.i2c_num_word_addr !== 1'b1)
      $display("FAIL rd_addr16 got=%h%h/%b exp=1234/1", bus.i2c_word_addr_h, bus.i2c_word_addr_l, bus.i2c_num_word_addr); else passed++;
    total++; if (bus.i2c_num_data_r !== 8'd3 || bus.i2c_num_data_w !== 8'd0)
      $display("FAIL rd_num_data got=r%0d w%0d exp=r3 w0", bus.i2c_num_data_r, bus.i2c_num_data_w); else passed++;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      bus.i2c_rdata = b; bus.i2c_rvalid = 1'b1;
      rd_q.push_back(b);
      tick();
      bus.i2c_rvalid = 1'b0; bus.i2c_rdata = ~b;
      if (req_rvalid[2]) rv++;
      e = rd_q.pop_front();
      total++; if (req_rvalid !== 4'b0100 || req_rdata !== e)
        $display("FAIL rd_byte[%0d] got=%b/%h exp=0100/%h", k, req_rvalid, req_rdata, e); else passed++;
      tick();
      if (req_rvalid[2]) rv++;
    end
    total++; if (rv != 4) $display("FAIL rd_rvalid_count got=%0d exp=4", rv); else passed++;
    bus.i2c_done = 1'b1;
    tick();
    bus.i2c_done = 1'b0;
    total++; if (req_done !== 4'b0100 || req_error !== '0) $display("FAIL rd_done got=%b/%b exp=0100/0000", req_done, req_error); else passed++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_fairness;
    logic [N-1:0] eg;
    logic [1:0]   een;
    rst = 1'b1; tick(); rst = 1'b0;
    clear_all();
    req_valid = '1; req_rw = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      eg  = N'(1) << (k % N);
      een = req_rw[k % N] ? 2'b01 : 2'b10;
      wait_grant();
      total++; if (req_grant !== eg) $display("FAIL fair_grant[%0d] got=%b exp=%b", k, req_grant, eg); else passed++;
      wait_enable();
      total++; if ({bus.i2c_wen, bus.i2c_ren} !== een) $display("FAIL fair_enable[%0d] got=%b exp=%b", k, {bus.i2c_wen, bus.i2c_ren}, een); else passed++;
      bus.i2c_done = 1'b1;
      tick();
      bus.i2c_done = 1'b0;
      total++; if (req_done !== eg) $display("FAIL fair_done[%0d] got=%b exp=%b", k, req_done, eg); else passed++;
      if (k == 4) req_valid = '0;
      tick();
    end
    tick();
  endtask

  task automatic test_nack;
    req_valid[1] = 1'b1; req_rw[1] = RW_WRITE; req_len[1] = 8'd0;
    wait_grant();
    total++; if (req_grant !== 4'b0010) $display("FAIL nack_grant got=%b exp=0010", req_grant); else passed++;
    wait_enable();
    bus.i2c_error = 1'b1;
    tick();
    bus.i2c_error = 1'b0;
    total++; if (req_done !== 4'b0010 || req_error !== 4'b0010)
      $display("FAIL nack_done_error got=%b/%b exp=0010/0010", req_done, req_error); else passed++;
    // Requesters 0 and 2 pending: the advanced pointer must pick 2.
    req_valid = 4'b0101;
    tick();
    wait_grant();
    total++; if (req_grant !== 4'b0100) $display("FAIL nack_ptr_advance got=%b exp=0100", req_grant); else passed++;
    wait_enable();
    bus.i2c_done = 1'b1; bus.i2c_error = 1'b1;
    tick();
    bus.i2c_done = 1'b0; bus.i2c_error = 1'b0;
    total++; if (req_done !== 4'b0100 || req_error !== 4'b0100)
      $display("FAIL done_with_error got=%b/%b exp=0100/0100", req_done, req_error); else passed++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_timeout;
    int unsigned cnt;
    req_valid[3] = 1'b1; req_rw[3] = RW_READ;
    wait_grant();
    total++; if (req_grant !== 4'b1000) $display("FAIL to_grant got=%b exp=1000", req_grant); else passed++;
    wait_enable();
    cnt = 0;
    while ((bus.i2c_wen || bus.i2c_ren) && cnt < 200) begin
      tick();
      cnt++;
    end
    total++; if (cnt != TO) $display("FAIL to_enable_cycles got=%0d exp=%0d", cnt, TO); else passed++;
    total++; if (req_done !== 4'b1000 || req_error !== 4'b1000)
      $display("FAIL to_abort got=%b/%b exp=1000/1000", req_done, req_error); else passed++;
    req_valid = 4'b0001;
    tick();
    wait_grant();
    total++; if (req_grant !== 4'b0001) $display("FAIL to_next_grant got=%b exp=0001", req_grant); else passed++;
    wait_enable();
    bus.i2c_done = 1'b1;
    tick();
    bus.i2c_done = 1'b0;
    total++; if (req_done !== 4'b0001 || req_error !== '0) $display("FAIL to_next_done got=%b/%b exp=0001/0000", req_done, req_error); else passed++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] e;
    req_valid[2] = 1'b1; req_rw[2] = RW_READ; req_dev[2] = 8'hA3; req_len[2] = 8'd1;
    wait_grant();
    total++; if (req_grant !== 4'b0100) $display("FAIL rst_pre_grant got=%b exp=0100", req_grant); else passed++;
    wait_enable();
    bus.i2c_rdata = 8'hC3; bus.i2c_rvalid = 1'b1;
    rd_q.push_back(8'hC3);
    tick();
    bus.i2c_rvalid = 1'b0;
    e = rd_q.pop_front();
    total++; if (req_rvalid !== 4'b0100 || req_rdata !== e) $display("FAIL rst_pre_byte got=%b/%h exp=0100/%h", req_rvalid, req_rdata, e); else passed++;
    rst = 1'b1;
    #1;
    total++; if (req_grant !== '0 || {bus.i2c_wen, bus.i2c_ren} !== 2'b00)
      $display("FAIL rst_mid_outputs got=grant%b en%b exp=0/00", req_grant, {bus.i2c_wen, bus.i2c_ren}); else passed++;
    total++; if (bus.i2c_device_addr !== '0 || req_rdata !== '0 || req_rvalid !== '0)
      $display("FAIL rst_mid_data got=%h/%h/%b exp=0/0/0", bus.i2c_device_addr, req_rdata, req_rvalid); else passed++;
    req_valid = 4'b0101;
    tick();
    total++; if (req_done !== '0 || req_error !== '0) $display("FAIL rst_no_done got=%b/%b exp=0/0", req_done, req_error); else passed++;
    rst = 1'b0;
    wait_grant();
    total++; if (req_grant !== 4'b0001) $display("FAIL rst_first_grant got=%b exp=0001", req_grant); else passed++;
    wait_enable();
    bus.i2c_done = 1'b1;
    tick();
    bus.i2c_done = 1'b0;
    req_valid = '0;
    total++; if (req_done !== 4'b0001) $display("FAIL rst_after_done got=%b exp=0001", req_done); else passed++;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read16();
    test_fairness();
    test_nack();
    test_timeout();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished passed=%0d total=%0d", passed, total);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter and transaction sequencer that shares one `I2C_Top` controller instance among `NUM_REQ` independent requesters (sensor poller, config loader, host bridge, ...). It latches a winning requester's command, drives the controller's command and enable inputs for one complete transaction, and routes write-data acknowledges, read data, completion and error back to that requester. A watchdog aborts transactions that never complete.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 2_000_000, max `clk` cycles from enable assertion to controller `done`/`error`; 0 disables the watchdog
- `clk` in 1 system clock
- `rst` in 1 asynchronous, active-high reset
- `req_valid` in NUM_REQ request pending, held until `req_done`
- `req_rw` in NUM_REQ per requester, 1 = read, 0 = write
- `req_dev` in NUM_REQ×8 device address (8-bit format)
- `req_addr` in NUM_REQ×16 word address; [15:8] is used only when `req_addr16`=1
- `req_addr16` in NUM_REQ 1 = 16-bit word address
- `req_len` in NUM_REQ×8 byte count minus 1
- `req_wdata` in NUM_REQ×8 current write byte
- `req_grant` out NUM_REQ one-hot owner, level
- `req_wack` out NUM_REQ write byte consumed, 1-cycle pulse
- `req_rdata` out 8 read byte, shared by all requesters
- `req_rvalid` out NUM_REQ `req_rdata` valid for the owner, 1-cycle pulse
- `req_done` out NUM_REQ transaction finished, 1-cycle pulse
- `req_error` out NUM_REQ qualifies `req_done`: NACK or timeout
- `i2c_device_addr`, `i2c_word_addr_h`, `i2c_word_addr_l` out 8 each, to controller
- `i2c_num_word_addr` out 1, to controller
- `i2c_num_data_w`, `i2c_num_data_r` out 8 each, to controller
- `i2c_wen`, `i2c_ren` out 1 each, to controller
- `i2c_wdata` out 8, to controller
- `i2c_wvalid`, `i2c_rvalid`, `i2c_done`, `i2c_error` in 1 each, from controller
- `i2c_rdata` in 8, from controller

## Operation
- States: `IDLE` → `GRANT` → `RUN` → `FINISH` → `IDLE`; plus `ABORT`.
- `IDLE`: if any `req_valid` is high, select the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ. Register the owner index and one-hot `req_grant`, then go to `GRANT`.
- `GRANT`: latch the owner's dev/addr/addr16/len/rw into the `i2c_*` command registers.
  - A write loads `num_data_w`=len and `num_data_r`=0.
  - A read loads `num_data_r`=len and `num_data_w`=0.
  - Go to `RUN`.
- `RUN`:
  - Hold `i2c_wen` (write) or `i2c_ren` (read) high; the other enable stays low.
  - `i2c_wdata` = `req_wdata[owner]`, combinational mux.
  - `i2c_wvalid` → `req_wack[owner]`. `i2c_rvalid` → `req_rvalid[owner]`, with `req_rdata` = `i2c_rdata`; both registered, 1 cycle latency.
  - On `i2c_done` or `i2c_error`, go to `FINISH`.
  - On a watchdog expiry, go to `ABORT`.
- `FINISH`:
  - Drop the enables.
  - Pulse `req_done[owner]`; `req_error[owner]` = latched `i2c_error`.
  - Set `rr_ptr` = owner+1 (wrapping), clear `req_grant`, go to `IDLE`.
- `ABORT`:
  - Drop the enables.
  - Pulse `req_done[owner]` and `req_error[owner]`.
  - Advance `rr_ptr`, go to `IDLE`.
- Command registers hold their value outside `GRANT`. Requester inputs may change freely after `GRANT`, except `req_wdata`.
- `req_valid` dropping during `RUN` is ignored; the transaction completes.

## Timing
- Reset: all outputs 0, `rr_ptr`=0, state `IDLE`, watchdog cleared.
- `req_valid` at cycle N (in `IDLE`):
  - `req_grant` high at N+1.
  - Command valid and `i2c_wen`/`i2c_ren` high at N+2.
- `i2c_done` at cycle M: enables low and `req_done` pulse at M+1, `req_grant` low at M+2. The next grant occurs no earlier than M+3.
- Simultaneous `i2c_done` and watchdog expiry: `i2c_done` wins, giving normal `FINISH`.
- `i2c_done` and `i2c_error` together: error reported.
- Watchdog:
  - Counts `clk` cycles in `RUN`, saturating, width `$clog2(TIMEOUT_CYCLES+1)`.
  - Expiry is when the count reaches `TIMEOUT_CYCLES`.
  - Cleared on entry to `RUN`.
- `rst` asserted mid-transaction: immediate return to reset values. No `req_done` is issued; requesters must re-request.

## Structure
- `i2c_pkg`:
  - `arb_state_e` state enum.
  - `i2c_cmd_t` struct {dev, addr_h, addr_l, addr16, len, rw}.
  - `RW_READ`/`RW_WRITE` constants.
- Sub-module `rr_select`: combinational round-robin picker (req vector, pointer → one-hot grant, index, any). Reusable for future bus arbiters.

## Test plan
- Single write: requester 0, dev 0xA0, addr 0x0010, len 2 → 3 `req_wack` pulses, `req_done[0]`=1, `req_error[0]`=0; `i2c_num_data_w`=2, `i2c_num_data_r`=0.
- 16-bit read: requester 2, addr 0x1234, addr16=1, len 3 → `i2c_word_addr_h`=0x12, `i2c_word_addr_l`=0x34, 4 `req_rvalid[2]` pulses carrying the model's bytes.
- Fairness: all four requesters held valid continuously → grant order 0,1,2,3,0; no requester is granted twice before the others are served.
- NACK: model asserts `i2c_error` → `req_done[1]` and `req_error[1]` pulse in the same cycle; `rr_ptr` advances to 2.
- Timeout: `TIMEOUT_CYCLES`=100 with the model never asserting done → enables drop, `req_done`+`req_error` pulse exactly 100 cycles after enable, then the next requester is granted.
- Reset mid-read: `rst` during `RUN` → all outputs 0 at the next edge, no `req_done`; after release, requester 0 is granted first.
